// File: rtl/interrupt_dispatcher_if.sv
// Interrupt dispatcher bus: latch/CPU side (master) and dispatcher side (slave).
interface interrupt_dispatcher_if #(
    parameter int NUM_LINES = 8
);
    logic [NUM_LINES-1:0]         Pending;
    logic [NUM_LINES-1:0]         Mask;
    logic                         IntEnable;
    logic                         Ack;
    logic                         Done;
    logic                         IRQ;
    logic [$clog2(NUM_LINES)-1:0] Vector;
    logic [$clog2(NUM_LINES):0]   CLR_Output;
    logic                         InService;

    modport master (
        output Pending, Mask, IntEnable, Ack, Done,
        input  IRQ, Vector, CLR_Output, InService
    );

    modport slave (
        input  Pending, Mask, IntEnable, Ack, Done,
        output IRQ, Vector, CLR_Output, InService
    );
endinterface

// File: rtl/interrupt_dispatcher.sv
// Interrupt dispatcher: picks the lowest-index enabled pending line, raises
// IRQ with its vector, waits for Ack (with timeout), emits a one-cycle clear
// code to the latch and blocks new requests until the ISR reports Done.
module interrupt_dispatcher #(
    parameter int NUM_LINES   = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input logic                   CLK,
    input logic                   Reset,
    interrupt_dispatcher_if.slave bus
);
    localparam int VEC_W = $clog2(NUM_LINES);
    localparam int CLR_W = VEC_W + 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CLEAR   = 2'd2,
        SERVICE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               irq_q, irq_d;
    logic [VEC_W-1:0]   vector_q, vector_d;
    logic [CLR_W-1:0]   clr_q, clr_d;
    logic               insvc_q, insvc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_LINES-1:0] qual;
    logic [VEC_W-1:0]     sel;
    logic                 abort;

    // Fixed-priority encoder over the qualified set: line 0 wins.
    always_comb begin
        qual = bus.Pending & bus.Mask;
        sel  = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (qual[i]) sel = VEC_W'(i);
        end
    end

    // A request is withdrawn when interrupts are disabled or its line vanished.
    assign abort = !bus.IntEnable || !bus.Pending[vector_q] || !bus.Mask[vector_q];

    // Next-state and next-output logic; clear code defaults to zero every cycle.
    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        vector_d = vector_q;
        clr_d    = '0;
        insvc_d  = insvc_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.IntEnable && (qual != '0)) begin
                    state_d  = REQ;
                    irq_d    = 1'b1;
                    vector_d = sel;
                    cnt_d    = '0;
                end
            end
            REQ: begin
                if (bus.Ack) begin
                    // Ack beats a simultaneous abort or timeout.
                    state_d = CLEAR;
                    irq_d   = 1'b0;
                    clr_d   = CLR_W'(vector_q) + CLR_W'(1);
                    insvc_d = 1'b1;
                end else if (abort || (cnt_q == CNT_LAST)) begin
                    state_d = IDLE;
                    irq_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CLEAR: begin
                state_d = SERVICE;
            end
            SERVICE: begin
                if (bus.Done) begin
                    state_d = IDLE;
                    insvc_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset wins over everything, no clear emitted.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            irq_q    <= 1'b0;
            vector_q <= '0;
            clr_q    <= '0;
            insvc_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            irq_q    <= irq_d;
            vector_q <= vector_d;
            clr_q    <= clr_d;
            insvc_q  <= insvc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.IRQ        = irq_q;
    assign bus.Vector     = vector_q;
    assign bus.CLR_Output = clr_q;
    assign bus.InService  = insvc_q;
endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Directed bench for interrupt_dispatcher with hand-computed expectations.
module tb_interrupt_dispatcher;
    logic CLK;
    logic Reset;
    int   tests;
    int   failed;
    int   irq_cycles;

    interrupt_dispatcher_if #(.NUM_LINES(8)) bus ();

    interrupt_dispatcher #(.NUM_LINES(8), .ACK_TIMEOUT(16)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int irq, input int vec,
                            input int clr, input int insvc);
        chk({tag, ".IRQ"},        int'(bus.IRQ),        irq);
        chk({tag, ".Vector"},     int'(bus.Vector),     vec);
        chk({tag, ".CLR_Output"}, int'(bus.CLR_Output), clr);
        chk({tag, ".InService"},  int'(bus.InService),  insvc);
    endtask

    // Linear sequence of directed steps.
    initial begin
        tests         = 0;
        failed        = 0;
        Reset         = 1'b1;
        bus.Pending   = 8'h00;
        bus.Mask      = 8'h00;
        bus.IntEnable = 1'b0;
        bus.Ack       = 1'b0;
        bus.Done      = 1'b0;
        tick();
        tick();
        chk_outs("reset", 0, 0, 0, 0);

        // 1: lowest index wins, full ack/clear/service round trip.
        Reset         = 1'b0;
        bus.Pending   = 8'h7F;
        bus.Mask      = 8'hFF;
        bus.IntEnable = 1'b1;
        tick();
        chk_outs("t1_req", 1, 0, 0, 0);
        bus.Ack = 1'b1;
        tick();
        chk_outs("t1_clear", 0, 0, 1, 1);
        bus.Ack     = 1'b0;
        bus.Pending = 8'h00;
        tick();
        chk_outs("t1_service", 0, 0, 0, 1);
        bus.Done = 1'b1;
        tick();
        chk_outs("t1_done", 0, 0, 0, 0);
        bus.Done = 1'b0;

        // 2: mask filters line 2, line 7 selected, clear code 8.
        bus.Pending = 8'h84;
        bus.Mask    = 8'h80;
        tick();
        chk_outs("t2_req", 1, 7, 0, 0);
        bus.Ack = 1'b1;
        tick();
        chk_outs("t2_clear", 0, 7, 8, 1);
        bus.Ack     = 1'b0;
        bus.Pending = 8'h00;
        tick();
        chk("t2_clr_one_cycle", int'(bus.CLR_Output), 0);
        bus.Done = 1'b1;
        tick();
        chk("t2_done", int'(bus.InService), 0);
        bus.Done = 1'b0;

        // 3: no ack, IRQ high exactly 16 cycles, then one idle cycle, re-arm.
        bus.Mask    = 8'hFF;
        bus.Pending = 8'h04;
        tick();
        chk_outs("t3_req", 1, 2, 0, 0);
        irq_cycles = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.IRQ !== 1'b1) break;
            irq_cycles++;
        end
        chk("t3_irq_cycles", irq_cycles, 16);
        chk("t3_timeout_irq", int'(bus.IRQ), 0);
        chk("t3_timeout_clr", int'(bus.CLR_Output), 0);
        tick();
        chk_outs("t3_rearm", 1, 2, 0, 0);

        // 4a: line drops during REQ, request withdrawn without clear.
        bus.Pending = 8'h00;
        tick();
        chk_outs("t4_drop", 0, 2, 0, 0);
        tick();
        chk("t4_drop_idle", int'(bus.IRQ), 0);

        // 4b: ack arriving on the timeout cycle still wins.
        bus.Pending = 8'h04;
        tick();
        chk_outs("t4_req", 1, 2, 0, 0);
        for (int i = 0; i < 15; i++) tick();
        chk("t4_pre_timeout_irq", int'(bus.IRQ), 1);
        bus.Ack = 1'b1;
        tick();
        chk_outs("t4_ack_on_timeout", 0, 2, 3, 1);
        bus.Ack     = 1'b0;
        bus.Pending = 8'h00;
        tick();
        chk_outs("t4_service", 0, 2, 0, 1);

        // 5: no nesting in SERVICE; arbitration resumes after Done.
        bus.Pending = 8'h01;
        tick();
        tick();
        tick();
        chk_outs("t5_no_nest", 0, 2, 0, 1);
        bus.Done = 1'b1;
        tick();
        chk_outs("t5_done", 0, 2, 0, 0);
        bus.Done = 1'b0;
        tick();
        chk_outs("t5_req", 1, 0, 0, 0);
        bus.Ack = 1'b1;
        tick();
        chk_outs("t5_clear", 0, 0, 1, 1);
        bus.Ack = 1'b0;
        tick();
        chk_outs("t5_service", 0, 0, 0, 1);

        // 5b: reset mid-SERVICE clears everything, no clear code.
        Reset = 1'b1;
        tick();
        chk_outs("t5_reset", 0, 0, 0, 0);
        Reset = 1'b0;
        tick();
        chk_outs("t5_after_reset", 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
